// File: rtl/obstacle_avoid_ctrl_if.sv
// Purpose: bundles the avoidance controller's run/ranging inputs and motor/status outputs.
// Latency: n/a, wires only.
// Backpressure: none; levels are sampled every cycle.
// Ports: enable, ssig, trig (ranging side) -> controller; motor_l, motor_r, pwm_l, pwm_r,
//        obstacle, state (motor driver / debug side) <- controller.
interface obstacle_avoid_ctrl_if;
  logic       enable;
  logic       ssig;
  logic       trig;
  logic [1:0] motor_l;
  logic [1:0] motor_r;
  logic       pwm_l;
  logic       pwm_r;
  logic       obstacle;
  logic [2:0] state;

  // master drives run request and ranging results, slave is the controller
  modport master (
    output enable, ssig, trig,
    input  motor_l, motor_r, pwm_l, pwm_r, obstacle, state
  );

  modport slave (
    input  enable, ssig, trig,
    output motor_l, motor_r, pwm_l, pwm_r, obstacle, state
  );
endinterface

// File: rtl/obstacle_avoid_ctrl.sv
// Purpose: filters the near-obstacle flag per ranging period and runs brake/reverse/turn avoidance.
// Latency: all outputs registered, one cycle after the state decision.
// Backpressure: none; trig rising edges define measurement periods, no handshake.
// Ports: clk0 clock, rst_n synchronous active-low reset, bus (slave) carries enable/ssig/trig in
//        and motor_l/motor_r/pwm_l/pwm_r/obstacle/state out.
module obstacle_avoid_ctrl #(
  parameter int HITS       = 3,
  parameter int BRAKE_CYC  = 5000000,
  parameter int REV_CYC    = 25000000,
  parameter int TURN_CYC   = 20000000,
  parameter int MAX_TURNS  = 4,
  parameter int PWM_PERIOD = 1000,
  parameter int FWD_DUTY   = 700,
  parameter int TURN_DUTY  = 500
) (
  input  logic                 clk0,
  input  logic                 rst_n,
  obstacle_avoid_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FWD   = 3'd1;
  localparam logic [2:0] BRAKE = 3'd2;
  localparam logic [2:0] REV   = 3'd3;
  localparam logic [2:0] TURN  = 3'd4;
  localparam logic [2:0] CHECK = 3'd5;
  localparam logic [2:0] HALT  = 3'd6;

  localparam int TMAX = (BRAKE_CYC > REV_CYC)
                        ? ((BRAKE_CYC > TURN_CYC) ? BRAKE_CYC : TURN_CYC)
                        : ((REV_CYC > TURN_CYC) ? REV_CYC : TURN_CYC);
  // timer only ever holds a phase length minus one
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int HW = $clog2(HITS + 1);
  localparam int CW = $clog2(MAX_TURNS + 1);
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int DW = $clog2(PWM_PERIOD + 1);

  logic [2:0]    state_q, state_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [HW-1:0] hit_q, hit_n;
  logic [CW-1:0] turn_q, turn_n;
  logic [PW-1:0] pwm_cnt_q, pwm_cnt_n;
  logic          trig_d;
  logic          chk_arm_q;
  logic          obstacle_q;
  logic [1:0]    motor_l_q, motor_r_q, motor_l_n, motor_r_n;
  logic          pwm_q;
  logic [DW-1:0] duty_n;
  logic          rise;

  assign rise = bus.trig & ~trig_d;

  // next state, phase timer and consecutive-failed-turn count
  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    turn_n  = turn_q;
    if (!bus.enable) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      case (state_q)
        IDLE: state_n = FWD;
        FWD: begin
          if (obstacle_q) begin
            state_n = BRAKE;
            timer_n = TW'(BRAKE_CYC - 1);
          end
        end
        BRAKE: begin
          if (timer_q == '0) begin
            state_n = REV;
            timer_n = TW'(REV_CYC - 1);
          end else begin
            timer_n = timer_q - 1'b1;
          end
        end
        REV: begin
          if (timer_q == '0) begin
            state_n = TURN;
            timer_n = TW'(TURN_CYC - 1);
          end else begin
            timer_n = timer_q - 1'b1;
          end
        end
        TURN: begin
          if (timer_q == '0) begin
            state_n = CHECK;
          end else begin
            timer_n = timer_q - 1'b1;
          end
        end
        CHECK: begin
          // chk_arm_q masks a rise that coincides with the first CHECK cycle
          if (chk_arm_q && rise) begin
            if (!bus.ssig) begin
              state_n = FWD;
              turn_n  = '0;
            end else begin
              turn_n = turn_q + 1'b1;
              if (turn_q == CW'(MAX_TURNS - 1)) begin
                state_n = HALT;
              end else begin
                state_n = TURN;
                timer_n = TW'(TURN_CYC - 1);
              end
            end
          end
        end
        HALT: state_n = HALT;
        default: state_n = IDLE;
      endcase
    end
    if (state_q == IDLE) turn_n = '0;
  end

  // obstacle filter: saturating hit counter over trig periods, flushed when FWD is left
  always_comb begin
    hit_n = hit_q;
    if (rise) begin
      if (bus.ssig) hit_n = (hit_q == HW'(HITS)) ? hit_q : hit_q + 1'b1;
      else          hit_n = '0;
    end
    if (state_q == FWD && state_n != FWD) hit_n = '0;
  end

  // motor/pwm are derived from the next state so they always match the state register
  always_comb begin
    motor_l_n = 2'b00;
    motor_r_n = 2'b00;
    duty_n    = '0;
    case (state_n)
      FWD: begin
        motor_l_n = 2'b10;
        motor_r_n = 2'b10;
        duty_n    = DW'(FWD_DUTY);
      end
      REV: begin
        motor_l_n = 2'b01;
        motor_r_n = 2'b01;
        duty_n    = DW'(TURN_DUTY);
      end
      TURN: begin
        motor_l_n = 2'b01;
        motor_r_n = 2'b10;
        duty_n    = DW'(TURN_DUTY);
      end
      default: ;
    endcase
  end

  assign pwm_cnt_n = (pwm_cnt_q == PW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + 1'b1;

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      hit_q      <= '0;
      turn_q     <= '0;
      pwm_cnt_q  <= '0;
      trig_d     <= 1'b0;
      chk_arm_q  <= 1'b0;
      obstacle_q <= 1'b0;
      motor_l_q  <= 2'b00;
      motor_r_q  <= 2'b00;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      timer_q    <= timer_n;
      hit_q      <= hit_n;
      turn_q     <= turn_n;
      pwm_cnt_q  <= pwm_cnt_n;
      trig_d     <= bus.trig;
      chk_arm_q  <= (state_q == CHECK) && (state_n == CHECK);
      obstacle_q <= (hit_n == HW'(HITS));
      motor_l_q  <= motor_l_n;
      motor_r_q  <= motor_r_n;
      pwm_q      <= (DW'(pwm_cnt_q) < duty_n);
    end
  end

  assign bus.state    = state_q;
  assign bus.obstacle = obstacle_q;
  assign bus.motor_l  = motor_l_q;
  assign bus.motor_r  = motor_r_q;
  assign bus.pwm_l    = pwm_q;
  assign bus.pwm_r    = pwm_q;

endmodule
